// File: rtl/pll_phase_sequencer.sv
// PLL dynamic phase sequencer: optional reference switch, lock qualification, then
// single-step phase moves on C0..C4/M until every counter reaches its target.
module pll_phase_sequencer #(
  parameter int LOCK_CYCLES = 8,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        updatepll,
  input  logic [47:0] pll_shifts,
  input  logic        pll_clk_src,
  input  logic        pll_locked,
  input  logic        phasedone,
  output logic [2:0]  phasecounterselect,
  output logic        phaseupdown,
  output logic        phasestep,
  output logic        clkswitch,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SWITCH, S_LOCKWAIT, S_SCAN, S_STEP, S_WAITLOW, S_WAITHIGH
  } state_t;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t      state_r;
  logic [7:0]  tgt_r [6];
  logic [7:0]  cur_r [6];
  logic        active_src_r;
  logic [2:0]  idx_r;
  logic [15:0] lockcnt_r;
  logic [15:0] tcnt_r;
  logic [1:0]  seq_cnt_r;

  // Entries 0..4 address C0..C4, entry 5 addresses the M counter.
  function automatic logic [2:0] counter_sel(input logic [2:0] entry);
    if (entry == 3'd5) begin
      return 3'b001;
    end else begin
      return entry + 3'd2;
    end
  endfunction

  // Sequencer state machine with all PLL-facing outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= S_IDLE;
      for (int i = 0; i < 6; i++) begin
        tgt_r[i] <= 8'd0;
        cur_r[i] <= 8'd0;
      end
      active_src_r       <= 1'b0;
      idx_r              <= 3'd0;
      lockcnt_r          <= 16'd0;
      tcnt_r             <= 16'd0;
      seq_cnt_r          <= 2'd0;
      phasecounterselect <= 3'b000;
      phaseupdown        <= 1'b0;
      phasestep          <= 1'b0;
      clkswitch          <= 1'b0;
      busy               <= 1'b0;
      error              <= 1'b0;
    end else begin
      // New targets are accepted in every state; a running sequence just steers toward them.
      if (updatepll) begin
        for (int i = 0; i < 6; i++) begin
          tgt_r[i] <= pll_shifts[8*i +: 8];
        end
      end

      case (state_r)
        S_IDLE: begin
          if (updatepll) begin
            error     <= 1'b0;
            idx_r     <= 3'd0;
            busy      <= 1'b1;
            lockcnt_r <= 16'd0;
            tcnt_r    <= 16'd0;
            seq_cnt_r <= 2'd0;
            if (pll_clk_src != active_src_r) begin
              clkswitch <= 1'b1;
              state_r   <= S_SWITCH;
            end else begin
              state_r   <= S_LOCKWAIT;
            end
          end
        end

        S_SWITCH: begin
          if (seq_cnt_r == 2'd3) begin
            clkswitch    <= 1'b0;
            active_src_r <= pll_clk_src;
            state_r      <= S_LOCKWAIT;
          end else begin
            seq_cnt_r <= seq_cnt_r + 2'd1;
          end
        end

        S_LOCKWAIT: begin
          if (pll_locked && (lockcnt_r == LOCK_LAST)) begin
            lockcnt_r <= 16'd0;
            state_r   <= S_SCAN;
          end else if (tcnt_r == TMO_LAST) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            lockcnt_r <= pll_locked ? lockcnt_r + 16'd1 : 16'd0;
            tcnt_r    <= tcnt_r + 16'd1;
          end
        end

        S_SCAN: begin
          if (idx_r == 3'd6) begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else if (cur_r[idx_r] == tgt_r[idx_r]) begin
            idx_r <= idx_r + 3'd1;
          end else begin
            // Select/direction land one cycle ahead of the strobe to give the PLL setup time.
            phasecounterselect <= counter_sel(idx_r);
            phaseupdown        <= (tgt_r[idx_r] > cur_r[idx_r]);
            seq_cnt_r          <= 2'd0;
            state_r            <= S_STEP;
          end
        end

        S_STEP: begin
          if (seq_cnt_r == 2'd0) begin
            phasestep <= 1'b1;
            seq_cnt_r <= 2'd1;
          end else if (seq_cnt_r == 2'd1) begin
            seq_cnt_r <= 2'd2;
          end else begin
            phasestep <= 1'b0;
            tcnt_r    <= 16'd0;
            state_r   <= S_WAITLOW;
          end
        end

        S_WAITLOW: begin
          if (!phasedone) begin
            tcnt_r  <= tcnt_r + 16'd1;
            state_r <= S_WAITHIGH;
          end else if (tcnt_r == TMO_LAST) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            tcnt_r <= tcnt_r + 16'd1;
          end
        end

        S_WAITHIGH: begin
          if (phasedone) begin
            cur_r[idx_r] <= phaseupdown ? cur_r[idx_r] + 8'd1 : cur_r[idx_r] - 8'd1;
            state_r      <= S_SCAN;
          end else if (tcnt_r == TMO_LAST) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            tcnt_r <= tcnt_r + 16'd1;
          end
        end

        default: begin
          phasestep <= 1'b0;
          clkswitch <= 1'b0;
          busy      <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Directed bench for pll_phase_sequencer with a behavioural PLL phasedone responder
// and a phasestep pulse recorder.
module tb_pll_phase_sequencer;

  logic        clk;
  logic        rst_n;
  logic        updatepll;
  logic [47:0] pll_shifts;
  logic        pll_clk_src;
  logic        pll_locked;
  logic        phasedone;
  logic [2:0]  phasecounterselect;
  logic        phaseupdown;
  logic        phasestep;
  logic        clkswitch;
  logic        busy;
  logic        error;

  int checks = 0;
  int fails  = 0;
  logic pd_stuck = 1'b0;

  typedef struct {
    logic [2:0] sel;
    logic       ud;
    int         len;
    logic       ok;
  } pulse_t;
  pulse_t pq[$];

  logic       ps_prev = 1'b0;
  logic [2:0] sel_prev = 3'd0;
  logic       ud_prev = 1'b0;
  int         run = 0;
  logic       run_ok = 1'b0;

  pll_phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .updatepll(updatepll), .pll_shifts(pll_shifts),
    .pll_clk_src(pll_clk_src), .pll_locked(pll_locked), .phasedone(phasedone),
    .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
    .phasestep(phasestep), .clkswitch(clkswitch), .busy(busy), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PLL model: phasedone drops 3 cycles after the strobe ends and returns 5 cycles later.
  initial begin
    phasedone = 1'b1;
    forever begin
      @(negedge phasestep);
      repeat (3) @(negedge clk);
      if (!pd_stuck) phasedone = 1'b0;
      repeat (5) @(negedge clk);
      phasedone = 1'b1;
    end
  end

  // Records each phasestep pulse with its select, direction, width and stability.
  always @(negedge clk) begin
    if (phasestep === 1'b1) begin
      if (!ps_prev) begin
        run    <= 1;
        run_ok <= (phasecounterselect === sel_prev) && (phaseupdown === ud_prev);
      end else begin
        run    <= run + 1;
        run_ok <= run_ok && (phasecounterselect === sel_prev) && (phaseupdown === ud_prev);
      end
    end else if (ps_prev) begin
      pq.push_back('{sel_prev, ud_prev, run, run_ok});
    end
    ps_prev  <= (phasestep === 1'b1);
    sel_prev <= phasecounterselect;
    ud_prev  <= phaseupdown;
  end

  task automatic pulse_update(input logic [47:0] sh, input logic src);
    @(negedge clk);
    pll_shifts  = sh;
    pll_clk_src = src;
    updatepll   = 1'b1;
    @(negedge clk);
    updatepll = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_after_update: got %b expected 1", busy);
      fails++;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL %s_idle_timeout: busy=%b expected 0 within %0d cycles", name, busy, budget);
      fails++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; updatepll = 1'b0; pll_shifts = 48'd0; pll_clk_src = 1'b0; pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({phasecounterselect, phaseupdown, phasestep, clkswitch, busy, error} !== 8'd0) begin
      $display("FAIL reset_outputs: got %b expected 00000000",
               {phasecounterselect, phaseupdown, phasestep, clkswitch, busy, error});
      fails++;
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || phasestep !== 1'b0) begin
      $display("FAIL reset_release_idle: busy=%b phasestep=%b expected 0 0", busy, phasestep);
      fails++;
    end
  endtask

  task automatic test_up_steps();
    pq.delete();
    pulse_update({40'd0, 8'd3}, 1'b0);
    wait_idle(2000, "up");
    checks++;
    if (pq.size() != 3) begin
      $display("FAIL up_pulse_count: got %0d expected 3", pq.size());
      fails++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= pq.size()) begin
        $display("FAIL up_pulse%0d: missing", i);
        fails++;
      end else if (pq[i].sel !== 3'b010 || pq[i].ud !== 1'b1 || pq[i].len != 2 || pq[i].ok !== 1'b1) begin
        $display("FAIL up_pulse%0d: sel=%b ud=%b len=%0d stable=%b expected 010 1 2 1",
                 i, pq[i].sel, pq[i].ud, pq[i].len, pq[i].ok);
        fails++;
      end
    end
    checks++;
    if (dut.cur_r[0] !== 8'd3) begin
      $display("FAIL up_cur0: got %0d expected 3", dut.cur_r[0]);
      fails++;
    end
  endtask

  task automatic test_down_up();
    logic [2:0] esel [4];
    logic       eud  [4];
    esel[0] = 3'b010; esel[1] = 3'b010; esel[2] = 3'b001; esel[3] = 3'b001;
    eud[0]  = 1'b0;   eud[1]  = 1'b0;   eud[2]  = 1'b1;   eud[3]  = 1'b1;
    pq.delete();
    pulse_update({8'd2, 32'd0, 8'd1}, 1'b0);
    wait_idle(2000, "downup");
    checks++;
    if (pq.size() != 4) begin
      $display("FAIL downup_pulse_count: got %0d expected 4", pq.size());
      fails++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= pq.size()) begin
        $display("FAIL downup_pulse%0d: missing", i);
        fails++;
      end else if (pq[i].sel !== esel[i] || pq[i].ud !== eud[i] || pq[i].len != 2 || pq[i].ok !== 1'b1) begin
        $display("FAIL downup_pulse%0d: sel=%b ud=%b len=%0d stable=%b expected %b %b 2 1",
                 i, pq[i].sel, pq[i].ud, pq[i].len, pq[i].ok, esel[i], eud[i]);
        fails++;
      end
    end
    checks++;
    if (dut.cur_r[0] !== 8'd1 || dut.cur_r[5] !== 8'd2) begin
      $display("FAIL downup_cur: cur0=%0d cur5=%0d expected 1 2", dut.cur_r[0], dut.cur_r[5]);
      fails++;
    end
  endtask

  task automatic test_clock_switch();
    int   n = 0;
    logic early = 1'b0;
    pq.delete();
    @(negedge clk);
    pll_locked = 1'b0;
    pulse_update({8'd2, 32'd0, 8'd4}, 1'b1);
    while (clkswitch === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 4) begin
      $display("FAIL switch_width: got %0d cycles expected 4", n);
      fails++;
    end
    repeat (3) begin
      @(negedge clk);
      if (phasestep !== 1'b0) early = 1'b1;
    end
    pll_locked = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (phasestep !== 1'b0) early = 1'b1;
    end
    pll_locked = 1'b0;
    @(negedge clk);
    if (phasestep !== 1'b0) early = 1'b1;
    pll_locked = 1'b1;
    checks++;
    if (early) begin
      $display("FAIL switch_early_step: got phasestep before lock qualified, expected none");
      fails++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phasestep !== 1'b1 && n < 40);
    checks++;
    if (n != 10) begin
      $display("FAIL switch_lock_latency: got %0d cycles expected 10", n);
      fails++;
    end
    wait_idle(2000, "switch");
    checks++;
    if (pq.size() != 3 || dut.cur_r[0] !== 8'd4) begin
      $display("FAIL switch_steps: pulses=%0d cur0=%0d expected 3 4", pq.size(), dut.cur_r[0]);
      fails++;
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    pd_stuck = 1'b1;
    pulse_update({8'd2, 32'd0, 8'd5}, 1'b1);
    while (phasestep !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (phasestep !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (error !== 1'b1 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 65535) begin
      $display("FAIL timeout_cycles: got %0d expected 65535", n);
      fails++;
    end
    checks++;
    if (busy !== 1'b0 || dut.cur_r[0] !== 8'd4) begin
      $display("FAIL timeout_state: busy=%b cur0=%0d expected 0 4", busy, dut.cur_r[0]);
      fails++;
    end
    pd_stuck = 1'b0;
    pulse_update({8'd2, 32'd0, 8'd4}, 1'b1);
    checks++;
    if (error !== 1'b0) begin
      $display("FAIL timeout_error_clear: got %b expected 0", error);
      fails++;
    end
    wait_idle(2000, "timeout");
  endtask

  task automatic test_reset_mid_step();
    int n = 0;
    pulse_update({8'd2, 32'd0, 8'd7}, 1'b1);
    while (phasestep !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({phasecounterselect, phaseupdown, phasestep, clkswitch, busy, error} !== 8'd0) begin
      $display("FAIL midreset_outputs: got %b expected 00000000",
               {phasecounterselect, phaseupdown, phasestep, clkswitch, busy, error});
      fails++;
    end
    checks++;
    if (dut.cur_r[0] !== 8'd0 || dut.cur_r[5] !== 8'd0) begin
      $display("FAIL midreset_cur: cur0=%0d cur5=%0d expected 0 0", dut.cur_r[0], dut.cur_r[5]);
      fails++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_retarget();
    int   n = 0;
    int   rises = 0;
    logic prev = 1'b0;
    pq.delete();
    pulse_update({40'd0, 8'd5}, 1'b0);
    while (rises < 2 && n < 300) begin
      @(negedge clk);
      n++;
      if (phasestep === 1'b1 && !prev) rises++;
      prev = (phasestep === 1'b1);
    end
    pulse_update({40'd0, 8'd2}, 1'b0);
    wait_idle(2000, "retarget");
    checks++;
    if (pq.size() != 2 || dut.cur_r[0] !== 8'd2) begin
      $display("FAIL retarget_result: pulses=%0d cur0=%0d expected 2 2", pq.size(), dut.cur_r[0]);
      fails++;
    end
    checks++;
    if (pq.size() >= 2 && (pq[0].ud !== 1'b1 || pq[1].ud !== 1'b1 || pq[1].len != 2)) begin
      $display("FAIL retarget_pulses: ud0=%b ud1=%b len1=%0d expected 1 1 2", pq[0].ud, pq[1].ud, pq[1].len);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_up_steps();
    test_down_up();
    test_clock_switch();
    test_timeout();
    test_reset_mid_step();
    test_retarget();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
